ultrasonido_sched: RTL

Round-robin measurement sequencer for up to four ultrasonic range sensors sharing one echo-width timer. For each sensor in turn it issues a fixed-width trigger pulse, waits for the echo rising edge, and measures the echo high time in clock cycles. It reports each result as a one-cycle strobe with sensor ID and timeout flag. It sits between the sensor pins and the distance-conversion/display logic.

---
 rtl/ultrasonido_pkg.sv | 53 +++++
 rtl/echo_sync.sv | 44 ++++
 rtl/ultrasonido_sched.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ultrasonido_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ultrasonido_pkg
//  Description : Shared types and constants for the ultrasonic sensor
//                sequencer. It holds the FSM state encoding and the default
//                timing constants for a 50 MHz clock. It also provides the
//                helper that picks the next enabled sensor.
//  Revision    : 1.0 - initial release
// ============================================================================
package ultrasonido_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        GAP       = 3'd4
    } state_t;

    // Defaults for a 50 MHz system clock
    localparam int c_trig_cycles  = 500;      // 10 us trigger pulse
    localparam int c_echo_timeout = 1900000;  // 38 ms max wait / echo width
    localparam int c_period       = 3000000;  // 60 ms trigger-to-trigger

    localparam int c_id_w        = 2;
    localparam int c_max_sensors = 4;

    // Returns the first sensor whose mask bit is set. The search is circular
    // and starts at cur, or at cur+1 when skip_cur is set. If no bit is set,
    // cur is returned unchanged and the caller decides what to do.
    function automatic logic [c_id_w-1:0] pick_sensor(
        input logic [c_max_sensors-1:0] mask,
        input logic [c_id_w-1:0]        cur,
        input int                       n,
        input logic                     skip_cur
    );
        int   start;
        int   idx;
        logic found;
        pick_sensor = cur;
        found       = 1'b0;
        start       = int'(cur) + (skip_cur ? 1 : 0);
        for (int k = 0; k < c_max_sensors; k++) begin
            idx = (start + k) % n;
            if (k < n && !found && mask[idx[1:0]]) begin
                pick_sensor = idx[1:0];
                found       = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/echo_sync.sv
`default_nettype none
// ============================================================================
//  Module      : echo_sync
//  Description : Two-flop synchronizer for one raw echo line. A third
//                registered copy provides single-cycle rise and fall pulses.
//  Ports       : clk     - system clock, rising edge
//                rst_n   - asynchronous active-low reset, all flops clear to 0
//                i_echo  - raw asynchronous echo input
//                o_level - synchronized echo level
//                o_rise  - synchronized level went 0 -> 1 this cycle
//                o_fall  - synchronized level went 1 -> 0 this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module echo_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_echo,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_echo;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/ultrasonido_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ultrasonido_sched
//  Description : Round-robin measurement sequencer for up to four ultrasonic
//                range sensors that share one echo-width timer. For each
//                sensor in turn it pulses the trigger, waits for the echo to
//                rise, and times the echo high width. Each result appears as
//                a one-cycle strobe with the sensor ID and a timeout flag.
//  Ports       : CLKOUT1      - system clock, rising edge
//                reset        - asynchronous active-low reset
//                enable       - scanning runs while high
//                echo         - raw asynchronous echo lines
//                sensor_mask  - per-sensor scan enable; present only when
//                               ULTRASONIDO_SCAN_MASK_EN is defined
//                trigger      - one-hot registered trigger pulses
//                dist_valid   - one-cycle result strobe
//                dist_id      - sensor index of the result
//                dist_cycles  - measured echo width in cycles
//                dist_timeout - result is a timeout (qualified by dist_valid)
//                busy         - high in every state except IDLE
//  Config      : ULTRASONIDO_SCAN_MASK_EN adds sensor_mask. Sensors with a 0
//                mask bit are skipped when selecting the next sensor.
//  Revision    : 1.0 - initial release
// ============================================================================
module ultrasonido_sched
    import ultrasonido_pkg::*;
#(
    parameter int NUM_SENSORS  = 4,
    parameter int TRIG_CYCLES  = c_trig_cycles,
    parameter int ECHO_TIMEOUT = c_echo_timeout,
    parameter int PERIOD       = c_period,
    parameter int CNT_W        = 22
) (
    input  logic                   CLKOUT1,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] echo,
`ifdef ULTRASONIDO_SCAN_MASK_EN
    input  logic [NUM_SENSORS-1:0] sensor_mask,
`endif
    output logic [NUM_SENSORS-1:0] trigger,
    output logic                   dist_valid,
    output logic [c_id_w-1:0]      dist_id,
    output logic [CNT_W-1:0]       dist_cycles,
    output logic                   dist_timeout,
    output logic                   busy
);

    // Per-sensor synchronized views, padded to four lanes so that the 2-bit
    // sensor select always indexes a full-width vector.
    logic [c_max_sensors-1:0] w_lvl;
    logic [c_max_sensors-1:0] w_rise;
    logic [c_max_sensors-1:0] w_fall;
    logic [c_max_sensors-1:0] w_mask;

    state_t            r_state;
    logic [CNT_W-1:0]  r_per;
    logic [CNT_W-1:0]  r_cnt;
    logic [c_id_w-1:0] r_sel;
    logic [c_id_w-1:0] w_first;
    logic [c_id_w-1:0] w_next;
    logic              w_any;

    for (genvar g = 0; g < c_max_sensors; g++) begin : g_echo
        if (g < NUM_SENSORS) begin : g_used
            echo_sync u_echo_sync (
                .clk     (CLKOUT1),
                .rst_n   (reset),
                .i_echo  (echo[g]),
                .o_level (w_lvl[g]),
                .o_rise  (w_rise[g]),
                .o_fall  (w_fall[g])
            );
        end else begin : g_unused
            assign w_lvl[g]  = 1'b0;
            assign w_rise[g] = 1'b0;
            assign w_fall[g] = 1'b0;
        end
    end

    for (genvar g = 0; g < c_max_sensors; g++) begin : g_mask
        if (g < NUM_SENSORS) begin : g_on
`ifdef ULTRASONIDO_SCAN_MASK_EN
            assign w_mask[g] = sensor_mask[g];
`else
            assign w_mask[g] = 1'b1;
`endif
        end else begin : g_off
            assign w_mask[g] = 1'b0;
        end
    end

    // When leaving IDLE the current select may itself be used. At the end of
    // GAP the search always starts at the sensor after the current one.
    assign w_any   = |w_mask;
    assign w_first = pick_sensor(w_mask, r_sel, NUM_SENSORS, 1'b0);
    assign w_next  = pick_sensor(w_mask, r_sel, NUM_SENSORS, 1'b1);

    always_ff @(posedge CLKOUT1 or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_per        <= '0;
            r_cnt        <= '0;
            r_sel        <= '0;
            trigger      <= '0;
            dist_valid   <= 1'b0;
            dist_id      <= '0;
            dist_cycles  <= '0;
            dist_timeout <= 1'b0;
            busy         <= 1'b0;
        end else begin
            dist_valid <= 1'b0;
            // The period counter runs from the cycle a trigger phase is
            // entered until the next one, so trigger starts are PERIOD apart.
            r_per <= (r_state == IDLE) ? '0 : r_per + CNT_W'(1);

            case (r_state)
                IDLE: begin
                    if (enable && w_any) begin
                        r_per   <= '0;
                        r_cnt   <= '0;
                        r_sel   <= w_first;
                        r_state <= TRIG;
                        busy    <= 1'b1;
                    end
                end

                // cnt runs 0..TRIG_CYCLES. Trigger is driven high on the
                // TRIG_CYCLES edges before the terminal count.
                TRIG: begin
                    if (r_cnt == CNT_W'(TRIG_CYCLES)) begin
                        trigger <= '0;
                        r_cnt   <= '0;
                        r_state <= WAIT_RISE;
                    end else begin
                        for (int i = 0; i < NUM_SENSORS; i++) begin
                            trigger[i] <= (r_sel == c_id_w'(i));
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                // Only a fresh rising edge counts. A level that is already
                // high on entry raised its edge earlier and is ignored until
                // it falls and rises again.
                WAIT_RISE: begin
                    if (w_rise[r_sel]) begin
                        r_cnt   <= CNT_W'(1);
                        r_state <= MEASURE;
                    end else if (r_cnt == CNT_W'(ECHO_TIMEOUT - 1)) begin
                        dist_valid   <= 1'b1;
                        dist_id      <= r_sel;
                        dist_cycles  <= '0;
                        dist_timeout <= 1'b1;
                        r_state      <= GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                // cnt already includes the first high cycle. Each further
                // high cycle adds one, so on the fall cnt equals the width.
                MEASURE: begin
                    if (w_fall[r_sel]) begin
                        dist_valid   <= 1'b1;
                        dist_id      <= r_sel;
                        dist_cycles  <= r_cnt;
                        dist_timeout <= 1'b0;
                        r_state      <= GAP;
                    end else if (w_lvl[r_sel]) begin
                        if (r_cnt == CNT_W'(ECHO_TIMEOUT - 1)) begin
                            dist_valid   <= 1'b1;
                            dist_id      <= r_sel;
                            dist_cycles  <= CNT_W'(ECHO_TIMEOUT);
                            dist_timeout <= 1'b1;
                            r_state      <= GAP;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end

                GAP: begin
                    if (r_per >= CNT_W'(PERIOD - 1)) begin
                        r_sel <= w_next;
                        r_cnt <= '0;
                        r_per <= '0;
                        if (enable && w_any) begin
                            r_state <= TRIG;
                        end else begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    trigger <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
